// File: rtl/burst_ram_arbiter.sv
// Two-master round-robin arbiter in front of a single BurstRAM port; grant is held for a whole burst.
// Optional statistics counters are built when BURST_RAM_ARBITER_STATS_EN is defined.
module burst_ram_arbiter #(
    parameter int unsigned RAM_DEPTH_BITWIDTH      = 4,
    parameter int unsigned RAM_BURST_DATA_BITWIDTH = 64,
    parameter int unsigned RAM_BURST_DATA_COUNT    = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,

    input  logic                                   m0_req,
    input  logic                                   m0_cmd,
    input  logic [RAM_DEPTH_BITWIDTH-1:0]          m0_addr,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]     m0_wr_data,
    input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0]   m0_data_mask,
    output logic                                   m0_wr_next,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]     m0_rd_data,
    output logic                                   m0_rd_data_valid,
    output logic                                   m0_done,

    input  logic                                   m1_req,
    input  logic                                   m1_cmd,
    input  logic [RAM_DEPTH_BITWIDTH-1:0]          m1_addr,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]     m1_wr_data,
    input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0]   m1_data_mask,
    output logic                                   m1_wr_next,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]     m1_rd_data,
    output logic                                   m1_rd_data_valid,
    output logic                                   m1_done,

    output logic                                   br_cmd,
    output logic                                   br_cmd_en,
    output logic [RAM_DEPTH_BITWIDTH-1:0]          br_addr,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]     br_wr_data,
    output logic [RAM_BURST_DATA_BITWIDTH/8-1:0]   br_data_mask,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]     br_rd_data,
    input  logic                                   br_rd_data_valid,
    input  logic                                   br_busy
);

    localparam int unsigned MASK_W = RAM_BURST_DATA_BITWIDTH / 8;
    localparam int unsigned CNT_W  = $clog2(RAM_BURST_DATA_COUNT + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(RAM_BURST_DATA_COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WRITE,
        S_READ,
        S_WAIT
    } state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic                            r_grant;
    logic                            w_grant_nxt;
    logic                            r_last_winner;
    logic                            w_last_nxt;
    logic [CNT_W-1:0]                r_cnt;
    logic [CNT_W-1:0]                w_cnt_nxt;
    logic                            w_arb;
    logic                            w_g_cmd;
    logic [RAM_DEPTH_BITWIDTH-1:0]   w_g_addr;
    logic [RAM_BURST_DATA_BITWIDTH-1:0] w_g_wr_data;
    logic [MASK_W-1:0]               w_g_mask;
    logic                            w_wr_next;
    logic                            w_rd_valid;
    logic                            w_done;

    // Granted master's request fields; on a tie the master that did not win last time is chosen.
    assign w_g_cmd     = r_grant ? m1_cmd       : m0_cmd;
    assign w_g_addr    = r_grant ? m1_addr      : m0_addr;
    assign w_g_wr_data = r_grant ? m1_wr_data   : m0_wr_data;
    assign w_g_mask    = r_grant ? m1_data_mask : m0_data_mask;
    assign w_arb       = (m0_req && m1_req) ? ~r_last_winner : m1_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_grant       <= 1'b0;
            r_last_winner <= 1'b1;
            r_cnt         <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_last_winner <= w_last_nxt;
            r_cnt         <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last_winner;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (!br_busy && (m0_req || m1_req)) begin
                    w_grant_nxt = w_arb;
                    w_last_nxt  = w_arb;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_g_cmd) begin
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = (RAM_BURST_DATA_COUNT == 1) ? S_WAIT : S_WRITE;
                end else begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_READ;
                end
            end
            S_WRITE: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt == LAST_BEAT) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_READ: begin
                if (br_rd_data_valid) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_BEAT) begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!br_busy) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // BurstRAM side is driven only while issuing or streaming write beats.
    always_comb begin
        br_cmd_en    = 1'b0;
        br_cmd       = 1'b0;
        br_addr      = '0;
        br_wr_data   = '0;
        br_data_mask = '0;
        w_wr_next    = 1'b0;
        w_rd_valid   = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_ISSUE: begin
                br_cmd_en = 1'b1;
                br_cmd    = w_g_cmd;
                br_addr   = w_g_addr;
                if (w_g_cmd) begin
                    br_wr_data   = w_g_wr_data;
                    br_data_mask = w_g_mask;
                    w_wr_next    = 1'b1;
                end
            end
            S_WRITE: begin
                br_wr_data   = w_g_wr_data;
                br_data_mask = w_g_mask;
                w_wr_next    = 1'b1;
            end
            S_READ:  w_rd_valid = br_rd_data_valid;
            S_WAIT:  w_done     = !br_busy;
            default: ;
        endcase
    end

    assign m0_wr_next       = w_wr_next  & ~r_grant;
    assign m1_wr_next       = w_wr_next  &  r_grant;
    assign m0_rd_data_valid = w_rd_valid & ~r_grant;
    assign m1_rd_data_valid = w_rd_valid &  r_grant;
    assign m0_done          = w_done     & ~r_grant;
    assign m1_done          = w_done     &  r_grant;
    assign m0_rd_data       = br_rd_data;
    assign m1_rd_data       = br_rd_data;

`ifdef BURST_RAM_ARBITER_STATS_EN
    logic [31:0] stat_grants_0;
    logic [31:0] stat_grants_1;
    logic [31:0] stat_conflicts;

    // Saturating usage counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_grants_0  <= '0;
            stat_grants_1  <= '0;
            stat_conflicts <= '0;
        end else begin
            if (r_state == S_ISSUE && !r_grant && stat_grants_0 != '1) begin
                stat_grants_0 <= stat_grants_0 + 32'd1;
            end
            if (r_state == S_ISSUE && r_grant && stat_grants_1 != '1) begin
                stat_grants_1 <= stat_grants_1 + 32'd1;
            end
            if (r_state == S_IDLE && !br_busy && m0_req && m1_req && stat_conflicts != '1) begin
                stat_conflicts <= stat_conflicts + 32'd1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Directed bench for burst_ram_arbiter with a small behavioural BurstRAM (3-cycle read latency, 4-beat bursts).
module tb_burst_ram_arbiter;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 64;
    localparam int unsigned MW = DW / 8;

    logic clk, rst;
    logic m0_req, m0_cmd, m0_wr_next, m0_rd_data_valid, m0_done;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wr_data, m0_rd_data;
    logic [MW-1:0] m0_data_mask;
    logic m1_req, m1_cmd, m1_wr_next, m1_rd_data_valid, m1_done;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wr_data, m1_rd_data;
    logic [MW-1:0] m1_data_mask;
    logic br_cmd, br_cmd_en, br_rd_data_valid, br_busy;
    logic [AW-1:0] br_addr;
    logic [DW-1:0] br_wr_data, br_rd_data;
    logic [MW-1:0] br_data_mask;

    logic ram_busy, ram_cmd, force_busy;
    logic [AW-1:0] ram_addr;
    logic [3:0] ram_t;
    logic [DW-1:0] mem [0:63];

    int n_tests, n_fail, cyc;
    int n_cmd, n_rd0, n_rd1, n_wr, n_wr0, n_done, left0, left1, wi1;
    logic [AW-1:0] cmd_addr [0:7];
    logic          cmd_cmd  [0:7];
    int            cmd_cyc  [0:7];
    logic [DW-1:0] rd0 [0:7];
    logic [DW-1:0] rd1 [0:7];
    logic [DW-1:0] wr_cap [0:7];
    int            wr_cyc [0:7];
    int            done_log [0:7];
    int            done_cyc [0:7];
    logic          done_busy [0:7];
    logic [MW-1:0] mask_or;
    logic [DW-1:0] wbeat [0:3];

    assign br_busy = ram_busy | force_busy;

    burst_ram_arbiter #(
        .RAM_DEPTH_BITWIDTH(AW),
        .RAM_BURST_DATA_BITWIDTH(DW),
        .RAM_BURST_DATA_COUNT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_cmd(m0_cmd), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
        .m0_data_mask(m0_data_mask), .m0_wr_next(m0_wr_next), .m0_rd_data(m0_rd_data),
        .m0_rd_data_valid(m0_rd_data_valid), .m0_done(m0_done),
        .m1_req(m1_req), .m1_cmd(m1_cmd), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
        .m1_data_mask(m1_data_mask), .m1_wr_next(m1_wr_next), .m1_rd_data(m1_rd_data),
        .m1_rd_data_valid(m1_rd_data_valid), .m1_done(m1_done),
        .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr), .br_wr_data(br_wr_data),
        .br_data_mask(br_data_mask), .br_rd_data(br_rd_data),
        .br_rd_data_valid(br_rd_data_valid), .br_busy(br_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, expected to finish earlier", $time);
        $fatal(1);
    end

    function automatic logic [DW-1:0] img(input int i);
        return {32'hA5A5_5A5A, 24'h0, 8'(i)};
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                            input logic [MW-1:0] mask);
        logic [DW-1:0] r;
        for (int b = 0; b < int'(MW); b++) r[8*b +: 8] = mask[b] ? old_w[8*b +: 8] : new_w[8*b +: 8];
        return r;
    endfunction

    // BurstRAM model: memory word index is {burst address, beat}.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_busy <= 1'b0; ram_cmd <= 1'b0; ram_addr <= '0; ram_t <= '0;
            br_rd_data_valid <= 1'b0; br_rd_data <= '0;
            for (int i = 0; i < 64; i++) mem[i] <= img(i);
        end else if (br_cmd_en) begin
            ram_busy <= 1'b1; ram_cmd <= br_cmd; ram_addr <= br_addr; ram_t <= 4'd1;
            br_rd_data_valid <= 1'b0;
            if (br_cmd) mem[{br_addr, 2'd0}] <= merge(mem[{br_addr, 2'd0}], br_wr_data, br_data_mask);
        end else if (ram_busy) begin
            ram_t <= ram_t + 4'd1;
            if (ram_cmd) begin
                mem[{ram_addr, ram_t[1:0]}] <= merge(mem[{ram_addr, ram_t[1:0]}], br_wr_data, br_data_mask);
                if (ram_t == 4'd3) ram_busy <= 1'b0;
            end else if (ram_t >= 4'd3 && ram_t <= 4'd6) begin
                br_rd_data_valid <= 1'b1;
                br_rd_data <= mem[{ram_addr, 2'(ram_t - 4'd3)}];
            end else begin
                br_rd_data_valid <= 1'b0;
                if (ram_t == 4'd7) ram_busy <= 1'b0;
            end
        end
    end

    task automatic clr();
        n_cmd = 0; n_rd0 = 0; n_rd1 = 0; n_wr = 0; n_wr0 = 0; n_done = 0; mask_or = '0;
        for (int i = 0; i < 8; i++) begin
            cmd_addr[i] = '1; cmd_cmd[i] = 1'bx; cmd_cyc[i] = -1; rd0[i] = '0; rd1[i] = '0;
            wr_cap[i] = '0; wr_cyc[i] = -1; done_log[i] = -1; done_cyc[i] = -1; done_busy[i] = 1'b1;
        end
    endtask

    // One clock: observe at the falling edge, then act just after the rising edge.
    task automatic step();
        logic adv1, d0, d1;
        @(negedge clk);
        cyc++;
        if (br_cmd_en) begin
            if (n_cmd < 8) begin cmd_addr[n_cmd] = br_addr; cmd_cmd[n_cmd] = br_cmd; cmd_cyc[n_cmd] = cyc; end
            n_cmd++;
        end
        if (m0_rd_data_valid) begin if (n_rd0 < 8) rd0[n_rd0] = m0_rd_data; n_rd0++; end
        if (m1_rd_data_valid) begin if (n_rd1 < 8) rd1[n_rd1] = m1_rd_data; n_rd1++; end
        if (m0_wr_next) n_wr0++;
        if (m1_wr_next) begin
            if (n_wr < 8) begin wr_cap[n_wr] = br_wr_data; wr_cyc[n_wr] = cyc; end
            mask_or = mask_or | br_data_mask;
            n_wr++;
        end
        if (m0_done || m1_done) begin
            if (n_done < 8) begin done_log[n_done] = m1_done ? 1 : 0; done_cyc[n_done] = cyc; done_busy[n_done] = br_busy; end
            n_done++;
        end
        adv1 = m1_wr_next; d0 = m0_done; d1 = m1_done;
        @(posedge clk);
        #1;
        if (adv1) begin wi1++; m1_wr_data = (wi1 < 4) ? wbeat[wi1[1:0]] : '0; end
        if (d0 && left0 > 0) begin left0--; if (left0 == 0) m0_req = 1'b0; end
        if (d1 && left1 > 0) begin left1--; if (left1 == 0) m1_req = 1'b0; end
    endtask

    task automatic start(input int n0, input int n1);
        left0 = n0; left1 = n1;
        m0_req = (n0 > 0); m1_req = (n1 > 0);
    endtask

    task automatic run(input int budget, input string name);
        int k = 0;
        while ((m0_req || m1_req) && k < budget) begin step(); k++; end
        n_tests++;
        if (m0_req || m1_req) begin
            n_fail++;
            $display("FAIL %s_timeout: requests still pending after %0d cycles, expected completion", name, budget);
            m0_req = 1'b0; m1_req = 1'b0;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; force_busy = 1'b0;
        m0_req = 1'b1; m0_cmd = 1'b1; m0_addr = '1; m0_wr_data = '1; m0_data_mask = '1;
        m1_req = 1'b1; m1_cmd = 1'b1; m1_addr = '1; m1_wr_data = '1; m1_data_mask = '1;
        repeat (3) @(negedge clk);
        n_tests++; if (br_cmd_en !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_en: got %b expected 0", br_cmd_en); end
        n_tests++; if (br_cmd !== 1'b0) begin n_fail++; $display("FAIL reset_cmd: got %b expected 0", br_cmd); end
        n_tests++; if (br_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", br_addr); end
        n_tests++; if (br_wr_data !== '0) begin n_fail++; $display("FAIL reset_wr_data: got %h expected 0", br_wr_data); end
        n_tests++; if (br_data_mask !== '0) begin n_fail++; $display("FAIL reset_mask: got %h expected 0", br_data_mask); end
        n_tests++;
        if ({m0_wr_next, m1_wr_next, m0_rd_data_valid, m1_rd_data_valid, m0_done, m1_done} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_master_outs: got %b expected 000000",
                     {m0_wr_next, m1_wr_next, m0_rd_data_valid, m1_rd_data_valid, m0_done, m1_done});
        end
`ifdef BURST_RAM_ARBITER_STATS_EN
        n_tests++; if (dut.stat_grants_0 !== 32'd0) begin n_fail++; $display("FAIL reset_stat_g0: got %0d expected 0", dut.stat_grants_0); end
`endif
        m0_req = 1'b0; m1_req = 1'b0; m0_cmd = 1'b0; m1_cmd = 1'b0;
        m0_addr = '0; m1_addr = '0; m0_wr_data = '0; m1_wr_data = '0; m0_data_mask = '0; m1_data_mask = '0;
        @(posedge clk);
        #1 rst = 1'b1;
        clr();
        repeat (4) step();
        n_tests++; if (n_cmd !== 0) begin n_fail++; $display("FAIL idle_no_cmd: got %0d commands expected 0", n_cmd); end
    endtask

    task automatic test_tie();
        clr();
        m0_cmd = 1'b0; m0_addr = 4'd1; m1_cmd = 1'b0; m1_addr = 4'd2;
        start(1, 1);
        run(100, "tie");
        n_tests++; if (n_cmd !== 2) begin n_fail++; $display("FAIL tie_cmd_cnt: got %0d expected 2", n_cmd); end
        n_tests++; if (cmd_addr[0] !== 4'd1) begin n_fail++; $display("FAIL tie_first_addr: got %0d expected 1", cmd_addr[0]); end
        n_tests++; if (cmd_addr[1] !== 4'd2) begin n_fail++; $display("FAIL tie_second_addr: got %0d expected 2", cmd_addr[1]); end
        n_tests++; if (done_log[0] !== 0 || done_log[1] !== 1) begin n_fail++; $display("FAIL tie_done_order: got %0d,%0d expected 0,1", done_log[0], done_log[1]); end
        n_tests++; if (!(cmd_cyc[1] > done_cyc[0])) begin n_fail++; $display("FAIL tie_m1_after_done: cmd cycle %0d, done cycle %0d, expected cmd later", cmd_cyc[1], done_cyc[0]); end
        n_tests++; if (n_rd0 !== 4 || n_rd1 !== 4) begin n_fail++; $display("FAIL tie_beats: got %0d/%0d expected 4/4", n_rd0, n_rd1); end
        n_tests++; if (rd0[0] !== img(4)) begin n_fail++; $display("FAIL tie_m0_data: got %h expected %h", rd0[0], img(4)); end
        n_tests++; if (rd1[3] !== img(11)) begin n_fail++; $display("FAIL tie_m1_data: got %h expected %h", rd1[3], img(11)); end
    endtask

    task automatic test_alternate();
        apply_reset();
        clr();
        m0_cmd = 1'b0; m0_addr = 4'd5; m1_cmd = 1'b0; m1_addr = 4'd6;
        start(2, 2);
        run(300, "alternate");
        n_tests++; if (n_done !== 4) begin n_fail++; $display("FAIL alt_done_cnt: got %0d expected 4", n_done); end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (done_log[i] !== i % 2) begin n_fail++; $display("FAIL alt_order_%0d: got master %0d expected %0d", i, done_log[i], i % 2); end
        end
`ifdef BURST_RAM_ARBITER_STATS_EN
        n_tests++; if (dut.stat_grants_0 !== 32'd2) begin n_fail++; $display("FAIL stat_grants_0: got %0d expected 2", dut.stat_grants_0); end
        n_tests++; if (dut.stat_grants_1 !== 32'd2) begin n_fail++; $display("FAIL stat_grants_1: got %0d expected 2", dut.stat_grants_1); end
        n_tests++; if (dut.stat_conflicts < 32'd3) begin n_fail++; $display("FAIL stat_conflicts: got %0d expected at least 3", dut.stat_conflicts); end
`endif
    endtask

    task automatic test_single_read();
        int s;
        clr();
        s = cyc;
        m0_cmd = 1'b0; m0_addr = 4'd0;
        start(1, 0);
        run(100, "single_read");
        n_tests++; if (n_cmd !== 1) begin n_fail++; $display("FAIL rd_cmd_cnt: got %0d expected 1", n_cmd); end
        n_tests++; if (cmd_addr[0] !== 4'd0 || cmd_cmd[0] !== 1'b0) begin n_fail++; $display("FAIL rd_cmd_fields: got addr %0d cmd %b expected 0/0", cmd_addr[0], cmd_cmd[0]); end
        n_tests++; if (cmd_cyc[0] !== s + 2) begin n_fail++; $display("FAIL rd_latency: got cycle %0d expected %0d", cmd_cyc[0], s + 2); end
        n_tests++; if (n_rd0 !== 4) begin n_fail++; $display("FAIL rd_m0_beats: got %0d expected 4", n_rd0); end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (rd0[i] !== img(i)) begin n_fail++; $display("FAIL rd_beat_%0d: got %h expected %h", i, rd0[i], img(i)); end
        end
        n_tests++; if (n_rd1 !== 0) begin n_fail++; $display("FAIL rd_m1_beats: got %0d expected 0", n_rd1); end
        n_tests++; if (n_done !== 1 || done_log[0] !== 0) begin n_fail++; $display("FAIL rd_done: got %0d pulses master %0d expected 1 pulse master 0", n_done, done_log[0]); end
        n_tests++; if (done_busy[0] !== 1'b0) begin n_fail++; $display("FAIL rd_done_busy: got busy %b at done expected 0", done_busy[0]); end
    endtask

    task automatic test_write_readback();
        clr();
        wbeat[0] = 64'h1111_1111_1111_1111; wbeat[1] = 64'h2222_2222_2222_2222;
        wbeat[2] = 64'h3333_3333_3333_3333; wbeat[3] = 64'h4444_4444_4444_4444;
        wi1 = 0; m1_wr_data = wbeat[0]; m1_data_mask = '0; m1_cmd = 1'b1; m1_addr = 4'd4;
        start(0, 1);
        run(100, "write");
        n_tests++; if (n_wr !== 4) begin n_fail++; $display("FAIL wr_next_cnt: got %0d expected 4", n_wr); end
        n_tests++; if (wr_cyc[3] - wr_cyc[0] !== 3) begin n_fail++; $display("FAIL wr_consecutive: got span %0d expected 3", wr_cyc[3] - wr_cyc[0]); end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (wr_cap[i] !== wbeat[i]) begin n_fail++; $display("FAIL wr_beat_%0d: got %h expected %h", i, wr_cap[i], wbeat[i]); end
        end
        n_tests++; if (mask_or !== '0) begin n_fail++; $display("FAIL wr_mask: got %h expected 0", mask_or); end
        n_tests++; if (n_wr0 !== 0) begin n_fail++; $display("FAIL wr_m0_next: got %0d expected 0", n_wr0); end
        m1_cmd = 1'b0; m1_wr_data = '0;
        clr();
        m0_cmd = 1'b0; m0_addr = 4'd4;
        start(1, 0);
        run(100, "readback");
        n_tests++; if (n_rd0 !== 4) begin n_fail++; $display("FAIL rb_beats: got %0d expected 4", n_rd0); end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (rd0[i] !== wbeat[i]) begin n_fail++; $display("FAIL rb_beat_%0d: got %h expected %h", i, rd0[i], wbeat[i]); end
        end
    endtask

    task automatic test_reset_mid_read();
        int k = 0;
        clr();
        m0_cmd = 1'b0; m0_addr = 4'd0;
        start(1, 0);
        while (n_rd0 < 2 && k < 60) begin step(); k++; end
        n_tests++; if (n_rd0 !== 2) begin n_fail++; $display("FAIL mid_two_beats: got %0d beats expected 2", n_rd0); end
        rst = 1'b0;
        #1;
        n_tests++;
        if ({br_cmd_en, br_cmd, m0_rd_data_valid, m1_rd_data_valid, m0_done, m1_done, m0_wr_next, m1_wr_next} !== 8'b0) begin
            n_fail++;
            $display("FAIL mid_reset_outs: got %b expected 00000000",
                     {br_cmd_en, br_cmd, m0_rd_data_valid, m1_rd_data_valid, m0_done, m1_done, m0_wr_next, m1_wr_next});
        end
        n_tests++; if (br_addr !== '0 || br_wr_data !== '0 || br_data_mask !== '0) begin n_fail++; $display("FAIL mid_reset_bus: got addr %h data %h mask %h expected 0", br_addr, br_wr_data, br_data_mask); end
        m0_req = 1'b0; left0 = 0;
        n_tests++; if (n_done !== 0) begin n_fail++; $display("FAIL mid_no_done: got %0d expected 0", n_done); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        clr();
        m1_cmd = 1'b0; m1_addr = 4'd3;
        start(0, 1);
        run(100, "after_reset");
        n_tests++; if (n_cmd !== 1 || cmd_addr[0] !== 4'd3) begin n_fail++; $display("FAIL post_cmd: got %0d cmds addr %0d expected 1 cmd addr 3", n_cmd, cmd_addr[0]); end
        n_tests++; if (n_rd1 !== 4 || n_rd0 !== 0) begin n_fail++; $display("FAIL post_beats: got m1 %0d m0 %0d expected 4/0", n_rd1, n_rd0); end
        n_tests++; if (rd1[0] !== img(12) || rd1[3] !== img(15)) begin n_fail++; $display("FAIL post_data: got %h,%h expected %h,%h", rd1[0], rd1[3], img(12), img(15)); end
        n_tests++; if (done_log[0] !== 1) begin n_fail++; $display("FAIL post_done: got master %0d expected 1", done_log[0]); end
    endtask

    task automatic test_busy_hold();
        int rel;
        clr();
        force_busy = 1'b1;
        m1_cmd = 1'b0; m1_addr = 4'd7;
        start(0, 1);
        repeat (6) step();
        n_tests++; if (n_cmd !== 0) begin n_fail++; $display("FAIL busy_no_cmd: got %0d commands expected 0", n_cmd); end
        force_busy = 1'b0;
        rel = cyc;
        run(100, "busy_hold");
        n_tests++; if (n_cmd !== 1) begin n_fail++; $display("FAIL busy_cmd_cnt: got %0d expected 1", n_cmd); end
        n_tests++; if (cmd_cyc[0] !== rel + 2) begin n_fail++; $display("FAIL busy_cmd_cycle: got %0d expected %0d", cmd_cyc[0], rel + 2); end
        n_tests++; if (n_rd1 !== 4 || rd1[0] !== img(28)) begin n_fail++; $display("FAIL busy_read: got %0d beats first %h expected 4 beats %h", n_rd1, rd1[0], img(28)); end
    endtask

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; wi1 = 0; left0 = 0; left1 = 0;
        for (int i = 0; i < 4; i++) wbeat[i] = '0;
        clr();
        test_reset();
        test_tie();
        test_alternate();
        test_single_read();
        test_write_readback();
        test_reset_mid_read();
        test_busy_hold();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/burst_ram_arbiter.md
Name: burst_ram_arbiter

Overview:
Shares one BurstRAM port between two bus masters: master 0 (instruction cache, read-only in practice) and master 1 (data cache, read/write). Round-robin grant per complete burst transaction; holds grant until the burst finishes and BurstRAM drops busy. Sits between CacheInstructions / data cache `br_*` ports and the single BurstRAM instance.

Parameters:
RAM_DEPTH_BITWIDTH, 4, width of the burst address (`br_addr`, `mN_addr`).
RAM_BURST_DATA_BITWIDTH, 64, width of one burst beat.
RAM_BURST_DATA_COUNT, 4, beats per burst (read or write).

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  asynchronous active-low reset (0 = reset asserted).
mN_req  in  1  (N=0,1) request; held high with cmd/addr stable until `mN_done`.
mN_cmd  in  1  0 = read burst, 1 = write burst.
mN_addr  in  RAM_DEPTH_BITWIDTH  burst address.
mN_wr_data  in  RAM_BURST_DATA_BITWIDTH  current write beat.
mN_data_mask  in  RAM_BURST_DATA_BITWIDTH/8  current beat byte mask, passed through unchanged.
mN_wr_next  out  1  beat consumed this cycle; master presents the next beat on the following cycle.
mN_rd_data  out  RAM_BURST_DATA_BITWIDTH  `br_rd_data` fanned out to both masters.
mN_rd_data_valid  out  1  `br_rd_data_valid` gated to the granted master only.
mN_done  out  1  one-cycle pulse: transaction complete, master may drop req.
br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask  out  —  to BurstRAM.
br_rd_data, br_rd_data_valid, br_busy  in  —  from BurstRAM.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, no grant, `last_winner`=1 (so master 0 wins the first tie). All outputs are 0: `br_cmd_en`, `br_cmd`, `br_addr`, `br_wr_data`, `br_data_mask`, `mN_wr_next`, `mN_rd_data_valid`, `mN_done`. Beat counter = 0.
- IDLE:
  - If `br_busy`=0 and any req: grant the requesting master. If both request, grant the master ≠ `last_winner`.
  - Register the grant and update `last_winner`; go to ISSUE.
  - If `br_busy`=1, stay in IDLE.
- ISSUE (1 cycle):
  - `br_cmd_en`=1; `br_cmd` and `br_addr` from the granted master.
  - Write: `br_wr_data`/`br_data_mask` = beat 0; `mG_wr_next`=1; beat counter = 1; go to WRITE (or WAIT if RAM_BURST_DATA_COUNT=1).
  - Read: beat counter = 0; go to READ.
- WRITE:
  - `br_cmd_en`=0. Beats pass through on consecutive cycles, one per cycle, with `mG_wr_next`=1 each cycle.
  - After beat RAM_BURST_DATA_COUNT-1, go to WAIT.
- READ:
  - `mG_rd_data_valid` = `br_rd_data_valid` combinationally; the other master sees 0.
  - Count valid beats. On beat RAM_BURST_DATA_COUNT, go to WAIT (the last beat is still delivered that cycle).
- WAIT:
  - When `br_busy`=0: `mG_done`=1 for one cycle, release grant, go to IDLE.
  - Earliest next grant is the cycle after `done`.
- Latency:
  - req → `br_cmd_en` ≥ 2 cycles (IDLE sample, ISSUE).
  - The losing master waits one full transaction.
- Requester protocol:
  - Dropping `mN_req` while granted is illegal. The arbiter ignores it and completes the burst.
  - req from the ungranted master is held pending; nothing is dropped.
- `br_*` outputs are driven 0 outside ISSUE/WRITE (`br_cmd_en` only in ISSUE).
- Reset mid-transaction aborts immediately to the reset state. BurstRAM shares rst and is reset too.
- Counter width is clog2(RAM_BURST_DATA_COUNT+1).

Optional Feature:
BURST_RAM_ARBITER_STATS_EN
- Defined: 32-bit registers `stat_grants_0`, `stat_grants_1` (+1 on each ISSUE for that master) and `stat_conflicts` (+1 each IDLE cycle where both req are high and a grant is made). All reset to 0 and saturate at all-ones. Bench reads them hierarchically.
- Undefined: the registers do not exist; functional behaviour is identical.

Test Plan:
Bench BurstRAM: CYCLES_BEFORE_DATA_VALID=3, BURST_COUNT=4, DEPTH_BITWIDTH=4, known memory image.
- After reset release, m0 read addr 0 → exactly one `br_cmd_en` pulse with `br_addr`=0, `br_cmd`=0. m0 gets 4 valid beats equal to the image words; m1 gets 0 valid beats. One `m0_done` pulse after `br_busy` falls.
- m0 and m1 raise req in the same cycle from IDLE → m0 granted first. m1's `br_cmd_en` comes only after `m0_done`; m1 is then served.
- m1 write addr 4, beats 64'h1111..1 to 64'h4444..4, mask 0 → 4 consecutive `m1_wr_next` pulses and `br_wr_data` in order. A following m0 read of addr 4 returns the same 4 words.
- m0 and m1 both re-request continuously for 4 transactions → grants alternate 0,1,0,1. With STATS_EN: `stat_grants_0`=2, `stat_grants_1`=2, `stat_conflicts`≥3.
- Assert rst=0 mid-READ after 2 beats → all outputs 0 asynchronously. After release, m1 read is granted first (`last_winner` reset to 1 ⇒ m0 preferred only on a tie) and completes with 4 beats.
- m1 req while `br_busy` is held high by a prior transaction → no `br_cmd_en` until `br_busy`=0.
